count_pwm_gen: RTL and testbench

- Downstream consumer of the free-running 4-bit synchronous counter; takes its count Q and produces a registered PWM output plus a once-per-period tick.
- Duty is written through a valid/ready handshake into a one-deep pending register.
- The pending duty is applied only at counter wrap, giving glitch-free period-aligned updates.
- Sits between the counter and downstream drive/LED logic.

---
 rtl/count_pwm_gen_pkg.sv | 17 +
 rtl/count_pwm_gen_wrap_detect.sv | 32 +++
 rtl/count_pwm_gen.sv | 91 +++++++++
 tb/tb_count_pwm_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/count_pwm_gen_pkg.sv
// Shared definitions for count_pwm_gen: FSM encoding, default counter width
// and the duty saturation limit.
package count_pwm_gen_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // Largest meaningful duty: the full period, 2^width counts.
    function automatic int duty_limit(input int width);
        return 1 << width;
    endfunction

endpackage

// File: rtl/count_pwm_gen_wrap_detect.sv
// Detects the counter's all-ones -> zero rollover and emits a registered
// one-cycle period tick the cycle after the rollover is seen.
module wrap_detect
    import count_pwm_gen_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Q,
    output logic             wrap,
    output logic             period_tick
);

    logic [WIDTH-1:0] q_prev_q;
    logic             tick_q;

    // A reload to zero from anything but all-ones is not a rollover.
    assign wrap        = (q_prev_q == {WIDTH{1'b1}}) && (Q == '0);
    assign period_tick = tick_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            q_prev_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            q_prev_q <= Q;
            tick_q   <= wrap;
        end
    end

endmodule

// File: rtl/count_pwm_gen.sv
// PWM generator driven by an external free-running counter; duty updates are
// taken through a one-deep handshake and applied only at counter rollover.
// Optional macro PWM_INVERT_EN inverts the output (idle level 1).
module count_pwm_gen
    import count_pwm_gen_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Q,
    input  logic [WIDTH:0]   duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_tick,
    output logic             running
);

    localparam int           DUTY_MAX_INT = duty_limit(WIDTH);
    localparam logic [WIDTH:0] DUTY_MAX   = (WIDTH + 1)'(DUTY_MAX_INT);

`ifdef PWM_INVERT_EN
    localparam logic IDLE_LVL = 1'b1;
`else
    localparam logic IDLE_LVL = 1'b0;
`endif

    logic           wrap;
    logic           accept;
    state_e         state_q, state_d;
    logic           pending_q, pending_d;
    logic [WIDTH:0] pending_duty_q, pending_duty_d;
    logic [WIDTH:0] active_duty_q, active_duty_d;
    logic           pwm_q, pwm_d;

    wrap_detect #(.WIDTH(WIDTH)) u_wrap_detect (
        .CLK        (CLK),
        .Reset      (Reset),
        .Q          (Q),
        .wrap       (wrap),
        .period_tick(period_tick)
    );

    assign accept     = duty_valid && !pending_q;
    assign duty_ready = !pending_q;
    assign running    = (state_q == S_RUN);
    assign pwm_out    = pwm_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q        <= S_IDLE;
            pending_q      <= 1'b0;
            pending_duty_q <= '0;
            active_duty_q  <= '0;
            pwm_q          <= IDLE_LVL;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            pending_duty_q <= pending_duty_d;
            active_duty_q  <= active_duty_d;
            pwm_q          <= pwm_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        pending_duty_d = pending_duty_q;
        active_duty_d  = active_duty_q;
        pwm_d          = IDLE_LVL;

        // Accept needs an empty slot and apply needs a full one, so the two
        // never coincide; a value accepted on a wrap waits for the next wrap.
        if (wrap && pending_q) begin
            active_duty_d = pending_duty_q;
            pending_d     = 1'b0;
            state_d       = S_RUN;
        end else if (accept) begin
            pending_d      = 1'b1;
            pending_duty_d = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
        end

        // Compare against the next-state duty so a new period starts cleanly
        // with its own duty from the rollover count onward.
        if (state_d == S_RUN) begin
            pwm_d = ({1'b0, Q} < active_duty_d) ^ IDLE_LVL;
        end
    end

endmodule

// File: tb/tb_count_pwm_gen.sv
// Directed bench for count_pwm_gen with a free-running 4-bit counter model.
module tb_count_pwm_gen;

`ifdef PWM_INVERT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] Q = 4'd0;
    logic [4:0] duty_in = 5'd0;
    logic       duty_valid = 1'b0;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_tick;
    logic       running;

    int checks = 0;
    int failures = 0;

    count_pwm_gen #(.WIDTH(4)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Q          (Q),
        .duty_in    (duty_in),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .pwm_out    (pwm_out),
        .period_tick(period_tick),
        .running    (running)
    );

    always #5 CLK = ~CLK;

    // One clock: outputs settle 1 time unit after the edge, then the counter advances.
    task automatic step();
        @(posedge CLK);
        #1;
        Q = Q + 4'd1;
    endtask

    task automatic wait_q(input logic [3:0] v);
        int n = 0;
        while (Q !== v && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (Q !== v) begin
            failures++;
            $display("FAIL wait_q: Q=%0d required %0d", Q, v);
        end
    endtask

    // Runs n cycles with duty d active; pwm seen at count Q reflects count Q-1.
    task automatic run_periods(input int d, input int n, input string tag);
        int   highs = 0;
        int   prevq;
        logic exp_pwm;
        for (int i = 0; i < n; i++) begin
            step();
            prevq   = (int'(Q) + 15) % 16;
            exp_pwm = logic'(prevq < d) ^ INV;
            checks++;
            if (pwm_out !== exp_pwm || period_tick !== (Q == 4'd1) || running !== 1'b1) begin
                failures++;
                $display("FAIL %s Q=%0d: pwm=%b tick=%b run=%b required pwm=%b tick=%b run=1",
                         tag, Q, pwm_out, period_tick, running, exp_pwm, (Q == 4'd1));
            end
            if (pwm_out === ~INV) highs++;
        end
        checks++;
        if (highs != ((d > 16 ? 16 : d) * n) / 16) begin
            failures++;
            $display("FAIL %s active_count: got %0d required %0d", tag, highs, ((d > 16 ? 16 : d) * n) / 16);
        end
        $display("run_periods %s duty=%0d cycles=%0d active=%0d", tag, d, n, highs);
    endtask

    // Offers a duty at count 6 and confirms the handshake takes it.
    task automatic write_duty(input logic [4:0] v, input string tag);
        wait_q(4'd6);
        duty_in    = v;
        duty_valid = 1'b1;
        checks++;
        if (duty_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_before: got %b required 1", tag, duty_ready);
        end
        step();
        duty_valid = 1'b0;
        checks++;
        if (duty_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s ready_after: got %b required 0", tag, duty_ready);
        end
        $display("write_duty %s value=%0d", tag, v);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (pwm_out !== INV || running !== 1'b0 || duty_ready !== 1'b1 || period_tick !== 1'b0) begin
                failures++;
                $display("FAIL reset cyc%0d: pwm=%b run=%b ready=%b tick=%b required %b/0/1/0",
                         i, pwm_out, running, duty_ready, period_tick, INV);
            end
        end
        Reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_duty4();
        write_duty(5'd4, "duty4");
        wait_q(4'd0);
        checks++;
        if (running !== 1'b0 || pwm_out !== INV) begin
            failures++;
            $display("FAIL duty4 pre_wrap: run=%b pwm=%b required 0/%b", running, pwm_out, INV);
        end
        run_periods(4, 32, "duty4");
    endtask

    task automatic test_boundaries();
        write_duty(5'd0, "duty0");
        wait_q(4'd0);
        run_periods(0, 16, "duty0");
        write_duty(5'd16, "duty16");
        wait_q(4'd0);
        run_periods(16, 16, "duty16");
        write_duty(5'd20, "duty20");
        wait_q(4'd0);
        run_periods(20, 16, "duty20sat");
        write_duty(5'd1, "duty1");
        wait_q(4'd0);
        run_periods(1, 16, "duty1");
    endtask

    task automatic test_back_to_back();
        write_duty(5'd16, "pre16");
        wait_q(4'd0);
        run_periods(16, 16, "pre16");
        // Now in the wrap cycle with nothing pending: offer 8 here.
        duty_in    = 5'd8;
        duty_valid = 1'b1;
        checks++;
        if (duty_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b ready_at_wrap: got %b required 1", duty_ready);
        end
        step();
        duty_in = 5'd2;
        checks++;
        if (duty_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b accepted: ready=%b required 0", duty_ready);
        end
        // 2 stays offered while the slot is full and must be ignored.
        run_periods(16, 15, "b2b_old");
        duty_valid = 1'b0;
        checks++;
        if (duty_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b still_pending: ready=%b required 0", duty_ready);
        end
        run_periods(8, 32, "b2b_new");
    endtask

    task automatic test_reset_mid();
        write_duty(5'd10, "duty10");
        wait_q(4'd0);
        run_periods(10, 16, "duty10");
        write_duty(5'd3, "pend3");
        wait_q(4'd9);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++;
        if (pwm_out !== INV || running !== 1'b0 || duty_ready !== 1'b1 || period_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: pwm=%b run=%b ready=%b tick=%b required %b/0/1/0",
                     pwm_out, running, duty_ready, period_tick, INV);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (pwm_out !== INV || running !== 1'b0 || duty_ready !== 1'b1 || period_tick !== (Q == 4'd1)) begin
                failures++;
                $display("FAIL post_reset Q=%0d: pwm=%b run=%b ready=%b tick=%b required %b/0/1/%b",
                         Q, pwm_out, running, duty_ready, period_tick, INV, (Q == 4'd1));
            end
        end
        $display("test_reset_mid idle window checked");
        write_duty(5'd4, "rearm4");
        wait_q(4'd0);
        run_periods(4, 16, "rearm4");
    endtask

    initial begin
        test_reset();
        test_duty4();
        test_boundaries();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
